// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Merges the I-cache and D-cache memory ports onto one memory
//               interface, routing read beats back to the owning cache.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int ADDR_BITS = 28,
    parameter int DATA_BITS = 128,
    parameter int BEATS     = 4
) (
    input  logic                   clk,
    input  logic                   reset,

    input  logic                   ic_mem_req_valid,
    output logic                   ic_mem_req_ready,
    input  logic [ADDR_BITS-1:0]   ic_mem_req_addr,
    input  logic                   ic_mem_req_rw,
    input  logic                   ic_mem_req_data_valid,
    output logic                   ic_mem_req_data_ready,
    input  logic [DATA_BITS-1:0]   ic_mem_req_data_bits,
    input  logic [DATA_BITS/8-1:0] ic_mem_req_data_mask,
    output logic                   ic_mem_resp_valid,
    output logic [DATA_BITS-1:0]   ic_mem_resp_data,

    input  logic                   dc_mem_req_valid,
    output logic                   dc_mem_req_ready,
    input  logic [ADDR_BITS-1:0]   dc_mem_req_addr,
    input  logic                   dc_mem_req_rw,
    input  logic                   dc_mem_req_data_valid,
    output logic                   dc_mem_req_data_ready,
    input  logic [DATA_BITS-1:0]   dc_mem_req_data_bits,
    input  logic [DATA_BITS/8-1:0] dc_mem_req_data_mask,
    output logic                   dc_mem_resp_valid,
    output logic [DATA_BITS-1:0]   dc_mem_resp_data,

    output logic                   mem_req_valid,
    input  logic                   mem_req_ready,
    output logic [ADDR_BITS-1:0]   mem_req_addr,
    output logic                   mem_req_rw,
    output logic                   mem_req_data_valid,
    input  logic                   mem_req_data_ready,
    output logic [DATA_BITS-1:0]   mem_req_data_bits,
    output logic [DATA_BITS/8-1:0] mem_req_data_mask,
    input  logic                   mem_resp_valid,
    input  logic [DATA_BITS-1:0]   mem_resp_data
);

    localparam int                    c_MASK_BITS = DATA_BITS / 8;
    localparam int                    c_CNT_BITS  = $clog2(BEATS + 1);
    localparam logic [c_CNT_BITS-1:0] c_LAST_BEAT = c_CNT_BITS'(BEATS - 1);
    localparam logic                  c_SEL_IC    = 1'b0;
    localparam logic                  c_SEL_DC    = 1'b1;

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_RD_BUSY = 1'b1
    } state_t;

    state_t                r_state;
    logic                  r_offer;
    logic                  r_owner;
    logic [c_CNT_BITS-1:0] r_count;

    logic w_idle;
    logic w_mem_rdy;
    logic w_ic_offered;
    logic w_dc_offered;
    logic w_sel_valid;
    logic w_sel_rw;
    logic w_fire;
    logic w_busy_beat;
    logic w_unused;

    // Readies depend only on state and memory readiness, never on cache valids,
    // so caches may safely drive valid combinationally from ready.
    assign w_idle       = (r_state == ST_IDLE) & ~reset;
    assign w_mem_rdy    = mem_req_ready & mem_req_data_ready;
    assign w_ic_offered = w_idle & (r_offer == c_SEL_IC);
    assign w_dc_offered = w_idle & (r_offer == c_SEL_DC);

    assign ic_mem_req_ready      = w_ic_offered & w_mem_rdy;
    assign ic_mem_req_data_ready = w_ic_offered & w_mem_rdy;
    assign dc_mem_req_ready      = w_dc_offered & w_mem_rdy;
    assign dc_mem_req_data_ready = w_dc_offered & w_mem_rdy;

    assign w_sel_valid = (w_ic_offered & ic_mem_req_valid) | (w_dc_offered & dc_mem_req_valid);
    assign w_sel_rw    = (r_offer == c_SEL_IC) ? ic_mem_req_rw : dc_mem_req_rw;
    assign w_fire      = w_sel_valid & w_mem_rdy;

    assign mem_req_valid      = w_fire;
    assign mem_req_data_valid = w_fire & w_sel_rw;

    always_comb begin
        mem_req_addr      = '0;
        mem_req_rw        = 1'b0;
        mem_req_data_bits = '0;
        mem_req_data_mask = '0;
        if (w_ic_offered) begin
            mem_req_addr      = ic_mem_req_addr;
            mem_req_rw        = ic_mem_req_rw;
            mem_req_data_bits = ic_mem_req_data_bits;
            mem_req_data_mask = ic_mem_req_data_mask;
        end else if (w_dc_offered) begin
            mem_req_addr      = dc_mem_req_addr;
            mem_req_rw        = dc_mem_req_rw;
            mem_req_data_bits = dc_mem_req_data_bits;
            mem_req_data_mask = dc_mem_req_data_mask;
        end
    end

    // Beats outside an outstanding read are dropped rather than routed.
    assign w_busy_beat       = (r_state == ST_RD_BUSY) & ~reset & mem_resp_valid;
    assign ic_mem_resp_valid = w_busy_beat & (r_owner == c_SEL_IC);
    assign dc_mem_resp_valid = w_busy_beat & (r_owner == c_SEL_DC);
    assign ic_mem_resp_data  = mem_resp_data;
    assign dc_mem_resp_data  = mem_resp_data;

    // Write data always travels with its request, so the data-valid strobes carry no extra information.
    assign w_unused = ^{ic_mem_req_data_valid, dc_mem_req_data_valid, c_MASK_BITS[0]};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_offer <= c_SEL_DC;
            r_owner <= c_SEL_DC;
            r_count <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_offer <= ~r_offer;
                    if (w_fire & ~w_sel_rw) begin
                        r_owner <= r_offer;
                        r_count <= '0;
                        r_state <= ST_RD_BUSY;
                    end
                end
                ST_RD_BUSY: begin
                    if (mem_resp_valid) begin
                        if (r_count == c_LAST_BEAT) begin
                            r_count <= '0;
                            r_state <= ST_IDLE;
                        end else begin
                            r_count <= r_count + c_CNT_BITS'(1);
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Scoreboard bench for mem_arbiter grant, forwarding and routing.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    localparam int ADDR_BITS = 28;
    localparam int DATA_BITS = 128;
    localparam int BEATS     = 4;
    localparam int MASK_BITS = DATA_BITS / 8;

    logic                 clk = 1'b0;
    logic                 reset;

    logic                 ic_mem_req_valid, ic_mem_req_ready, ic_mem_req_rw;
    logic [ADDR_BITS-1:0] ic_mem_req_addr;
    logic                 ic_mem_req_data_valid, ic_mem_req_data_ready;
    logic [DATA_BITS-1:0] ic_mem_req_data_bits;
    logic [MASK_BITS-1:0] ic_mem_req_data_mask;
    logic                 ic_mem_resp_valid;
    logic [DATA_BITS-1:0] ic_mem_resp_data;

    logic                 dc_mem_req_valid, dc_mem_req_ready, dc_mem_req_rw;
    logic [ADDR_BITS-1:0] dc_mem_req_addr;
    logic                 dc_mem_req_data_valid, dc_mem_req_data_ready;
    logic [DATA_BITS-1:0] dc_mem_req_data_bits;
    logic [MASK_BITS-1:0] dc_mem_req_data_mask;
    logic                 dc_mem_resp_valid;
    logic [DATA_BITS-1:0] dc_mem_resp_data;

    logic                 mem_req_valid, mem_req_ready, mem_req_rw;
    logic [ADDR_BITS-1:0] mem_req_addr;
    logic                 mem_req_data_valid, mem_req_data_ready;
    logic [DATA_BITS-1:0] mem_req_data_bits;
    logic [MASK_BITS-1:0] mem_req_data_mask;
    logic                 mem_resp_valid;
    logic [DATA_BITS-1:0] mem_resp_data;

    int checks = 0;
    int errors = 0;
    logic [DATA_BITS-1:0] exp_ic_q[$];
    logic [DATA_BITS-1:0] exp_dc_q[$];

    mem_arbiter #(
        .ADDR_BITS(ADDR_BITS),
        .DATA_BITS(DATA_BITS),
        .BEATS    (BEATS)
    ) dut (
        .clk                  (clk),
        .reset                (reset),
        .ic_mem_req_valid     (ic_mem_req_valid),
        .ic_mem_req_ready     (ic_mem_req_ready),
        .ic_mem_req_addr      (ic_mem_req_addr),
        .ic_mem_req_rw        (ic_mem_req_rw),
        .ic_mem_req_data_valid(ic_mem_req_data_valid),
        .ic_mem_req_data_ready(ic_mem_req_data_ready),
        .ic_mem_req_data_bits (ic_mem_req_data_bits),
        .ic_mem_req_data_mask (ic_mem_req_data_mask),
        .ic_mem_resp_valid    (ic_mem_resp_valid),
        .ic_mem_resp_data     (ic_mem_resp_data),
        .dc_mem_req_valid     (dc_mem_req_valid),
        .dc_mem_req_ready     (dc_mem_req_ready),
        .dc_mem_req_addr      (dc_mem_req_addr),
        .dc_mem_req_rw        (dc_mem_req_rw),
        .dc_mem_req_data_valid(dc_mem_req_data_valid),
        .dc_mem_req_data_ready(dc_mem_req_data_ready),
        .dc_mem_req_data_bits (dc_mem_req_data_bits),
        .dc_mem_req_data_mask (dc_mem_req_data_mask),
        .dc_mem_resp_valid    (dc_mem_resp_valid),
        .dc_mem_resp_data     (dc_mem_resp_data),
        .mem_req_valid        (mem_req_valid),
        .mem_req_ready        (mem_req_ready),
        .mem_req_addr         (mem_req_addr),
        .mem_req_rw           (mem_req_rw),
        .mem_req_data_valid   (mem_req_data_valid),
        .mem_req_data_ready   (mem_req_data_ready),
        .mem_req_data_bits    (mem_req_data_bits),
        .mem_req_data_mask    (mem_req_data_mask),
        .mem_resp_valid       (mem_resp_valid),
        .mem_resp_data        (mem_resp_data)
    );

    always #5 clk = ~clk;

    // Scoreboard consumer: every routed beat must match the head of its cache's queue.
    always @(negedge clk) begin : resp_monitor
        logic [DATA_BITS-1:0] exp;
        #3;
        if (ic_mem_resp_valid) begin
            checks++;
            if (exp_ic_q.size() == 0) begin
                errors++;
                $display("FAIL ic_resp_unexpected got=%h exp=none", ic_mem_resp_data);
            end else begin
                exp = exp_ic_q.pop_front();
                if (ic_mem_resp_data !== exp) begin
                    errors++;
                    $display("FAIL ic_resp_data got=%h exp=%h", ic_mem_resp_data, exp);
                end
            end
        end
        if (dc_mem_resp_valid) begin
            checks++;
            if (exp_dc_q.size() == 0) begin
                errors++;
                $display("FAIL dc_resp_unexpected got=%h exp=none", dc_mem_resp_data);
            end else begin
                exp = exp_dc_q.pop_front();
                if (dc_mem_resp_data !== exp) begin
                    errors++;
                    $display("FAIL dc_resp_data got=%h exp=%h", dc_mem_resp_data, exp);
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic drive_idle();
        ic_mem_req_valid      = 1'b0;
        ic_mem_req_addr       = '0;
        ic_mem_req_rw         = 1'b0;
        ic_mem_req_data_valid = 1'b0;
        ic_mem_req_data_bits  = '0;
        ic_mem_req_data_mask  = '0;
        dc_mem_req_valid      = 1'b0;
        dc_mem_req_addr       = '0;
        dc_mem_req_rw         = 1'b0;
        dc_mem_req_data_valid = 1'b0;
        dc_mem_req_data_bits  = '0;
        dc_mem_req_data_mask  = '0;
        mem_resp_valid        = 1'b0;
        mem_resp_data         = '0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive_idle();
        mem_req_ready      = 1'b1;
        mem_req_data_ready = 1'b1;
        tick();
        tick();
        #1;
        checks++;
        if ({ic_mem_req_ready, dc_mem_req_ready, ic_mem_req_data_ready, dc_mem_req_data_ready,
             mem_req_valid, mem_req_data_valid, ic_mem_resp_valid, dc_mem_resp_valid} !== 8'h00) begin
            errors++;
            $display("FAIL reset_outputs got=%b exp=00000000",
                     {ic_mem_req_ready, dc_mem_req_ready, ic_mem_req_data_ready, dc_mem_req_data_ready,
                      mem_req_valid, mem_req_data_valid, ic_mem_resp_valid, dc_mem_resp_valid});
        end
        checks++;
        if (mem_req_addr !== '0 || mem_req_data_bits !== '0 || mem_req_data_mask !== '0) begin
            errors++;
            $display("FAIL reset_fields got=%h/%h exp=0", mem_req_addr, mem_req_data_mask);
        end
        tick();
        reset = 1'b0;
        #1;
        checks++;
        if ({ic_mem_req_ready, dc_mem_req_ready} !== 2'b01) begin
            errors++;
            $display("FAIL reset_offer_dc got=%b exp=01", {ic_mem_req_ready, dc_mem_req_ready});
        end
        tick();
    endtask

    task automatic test_read_only();
        logic got;
        ic_mem_req_valid = 1'b1;
        ic_mem_req_addr  = 28'h0000040;
        ic_mem_req_rw    = 1'b0;
        got = 1'b0;
        for (int w = 0; w < 3 && !got; w++) begin
            #1;
            if (ic_mem_req_ready) got = 1'b1;
            else tick();
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL rd_grant_timeout got=no_ready exp=ready");
        end else begin
            checks++;
            if ({mem_req_valid, mem_req_data_valid, mem_req_rw} !== 3'b100 || mem_req_addr !== 28'h0000040) begin
                errors++;
                $display("FAIL rd_forward got=%b addr=%h exp=100 addr=0000040",
                         {mem_req_valid, mem_req_data_valid, mem_req_rw}, mem_req_addr);
            end
            tick();
            ic_mem_req_valid = 1'b0;
            for (int k = 0; k < BEATS; k++) begin
                mem_resp_valid = 1'b1;
                mem_resp_data  = {4{32'hA0A0_0000 + 32'(k)}};
                exp_ic_q.push_back(mem_resp_data);
                #1;
                checks++;
                if ({ic_mem_req_ready, dc_mem_req_ready, ic_mem_resp_valid, dc_mem_resp_valid} !== 4'b0010) begin
                    errors++;
                    $display("FAIL rd_busy_beat%0d got=%b exp=0010", k,
                             {ic_mem_req_ready, dc_mem_req_ready, ic_mem_resp_valid, dc_mem_resp_valid});
                end
                tick();
            end
            mem_resp_valid = 1'b0;
            #1;
            checks++;
            if ((ic_mem_req_ready ^ dc_mem_req_ready) !== 1'b1) begin
                errors++;
                $display("FAIL rd_idle_after_last got=%b exp=one_ready", {ic_mem_req_ready, dc_mem_req_ready});
            end
            checks++;
            if (exp_ic_q.size() != 0) begin
                errors++;
                $display("FAIL rd_beats_missing got=%0d exp=0", exp_ic_q.size());
            end
            tick();
        end
        drive_idle();
    endtask

    task automatic test_write_only();
        logic got;
        dc_mem_req_valid      = 1'b1;
        dc_mem_req_addr       = 28'h0000123;
        dc_mem_req_rw         = 1'b1;
        dc_mem_req_data_valid = 1'b1;
        dc_mem_req_data_mask  = 16'h00F0;
        dc_mem_req_data_bits  = 128'h0123_4567_89AB_CDEF_DEAD_BEEF_0011_2233;
        got = 1'b0;
        for (int w = 0; w < 3 && !got; w++) begin
            #1;
            if (dc_mem_req_ready) got = 1'b1;
            else tick();
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL wr_grant_timeout got=no_ready exp=ready");
        end else begin
            checks++;
            if ({mem_req_valid, mem_req_data_valid, mem_req_rw, dc_mem_req_data_ready} !== 4'b1111) begin
                errors++;
                $display("FAIL wr_valids got=%b exp=1111",
                         {mem_req_valid, mem_req_data_valid, mem_req_rw, dc_mem_req_data_ready});
            end
            checks++;
            if (mem_req_addr !== 28'h0000123 || mem_req_data_mask !== 16'h00F0 ||
                mem_req_data_bits !== 128'h0123_4567_89AB_CDEF_DEAD_BEEF_0011_2233) begin
                errors++;
                $display("FAIL wr_fields got=%h/%h/%h exp=0000123/00f0/0123456789abcdefdeadbeef00112233",
                         mem_req_addr, mem_req_data_mask, mem_req_data_bits);
            end
            tick();
            drive_idle();
            #1;
            checks++;
            if ({ic_mem_req_ready, dc_mem_req_ready} !== 2'b10) begin
                errors++;
                $display("FAIL wr_stays_idle got=%b exp=10", {ic_mem_req_ready, dc_mem_req_ready});
            end
            tick();
            #1;
            checks++;
            if ({ic_mem_req_ready, dc_mem_req_ready} !== 2'b01) begin
                errors++;
                $display("FAIL wr_offer_flip got=%b exp=01", {ic_mem_req_ready, dc_mem_req_ready});
            end
            tick();
        end
        drive_idle();
    endtask

    task automatic test_backpressure();
        logic got;
        mem_req_ready    = 1'b0;
        dc_mem_req_valid = 1'b1;
        dc_mem_req_addr  = 28'h0000077;
        dc_mem_req_rw    = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #1;
            checks++;
            if ({ic_mem_req_ready, dc_mem_req_ready, mem_req_valid} !== 3'b000) begin
                errors++;
                $display("FAIL bp_hold%0d got=%b exp=000", c, {ic_mem_req_ready, dc_mem_req_ready, mem_req_valid});
            end
            tick();
        end
        mem_req_ready = 1'b1;
        got = 1'b0;
        for (int w = 0; w < 2 && !got; w++) begin
            #1;
            if (dc_mem_req_ready && mem_req_valid) got = 1'b1;
            else tick();
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL bp_fire_timeout got=no_fire exp=fire_within_2");
        end else begin
            checks++;
            if (mem_req_addr !== 28'h0000077 || mem_req_rw !== 1'b0) begin
                errors++;
                $display("FAIL bp_forward got=%h exp=0000077", mem_req_addr);
            end
            tick();
            dc_mem_req_valid = 1'b0;
            for (int k = 0; k < BEATS; k++) begin
                mem_resp_valid = 1'b1;
                mem_resp_data  = {4{32'hB0B0_0000 + 32'(k)}};
                exp_dc_q.push_back(mem_resp_data);
                tick();
            end
            mem_resp_valid = 1'b0;
            #1;
            checks++;
            if (exp_dc_q.size() != 0) begin
                errors++;
                $display("FAIL bp_beats_missing got=%0d exp=0", exp_dc_q.size());
            end
            tick();
        end
        drive_idle();
    endtask

    task automatic test_contention();
        logic                 is_dc;
        logic [ADDR_BITS-1:0] exp_addr;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        ic_mem_req_valid = 1'b1;
        dc_mem_req_valid = 1'b1;
        for (int g = 0; g < 8; g++) begin
            is_dc           = (g % 2 == 0);
            ic_mem_req_addr = 28'h0000100 + 28'(g);
            dc_mem_req_addr = 28'h0000200 + 28'(g);
            exp_addr        = is_dc ? dc_mem_req_addr : ic_mem_req_addr;
            #1;
            checks++;
            if ({ic_mem_req_ready, dc_mem_req_ready} !== {~is_dc, is_dc} ||
                mem_req_valid !== 1'b1 || mem_req_addr !== exp_addr) begin
                errors++;
                $display("FAIL cont_grant%0d got=%b addr=%h exp=%b addr=%h", g,
                         {ic_mem_req_ready, dc_mem_req_ready}, mem_req_addr, {~is_dc, is_dc}, exp_addr);
            end
            tick();
            for (int k = 0; k < BEATS; k++) begin
                mem_resp_valid = 1'b1;
                mem_resp_data  = {96'h0, 32'hC0DE_0000 + 32'(g * 16 + k)};
                if (is_dc) exp_dc_q.push_back(mem_resp_data);
                else       exp_ic_q.push_back(mem_resp_data);
                #1;
                checks++;
                if ({ic_mem_req_ready, dc_mem_req_ready} !== 2'b00) begin
                    errors++;
                    $display("FAIL cont_busy_ready g%0d k%0d got=%b exp=00", g, k,
                             {ic_mem_req_ready, dc_mem_req_ready});
                end
                tick();
            end
            mem_resp_valid = 1'b0;
        end
        drive_idle();
        #1;
        checks++;
        if (exp_ic_q.size() != 0 || exp_dc_q.size() != 0) begin
            errors++;
            $display("FAIL cont_beats_missing got=%0d/%0d exp=0/0", exp_ic_q.size(), exp_dc_q.size());
        end
        tick();
    endtask

    task automatic test_reset_mid_read();
        logic got;
        for (int pass = 0; pass < 2; pass++) begin
            ic_mem_req_valid = 1'b1;
            ic_mem_req_addr  = 28'h0000300 + 28'(pass);
            ic_mem_req_rw    = 1'b0;
            got = 1'b0;
            for (int w = 0; w < 3 && !got; w++) begin
                #1;
                if (ic_mem_req_ready) got = 1'b1;
                else tick();
            end
            checks++;
            if (!got) begin
                errors++;
                $display("FAIL rst_mid_grant%0d_timeout got=no_ready exp=ready", pass);
            end else begin
                tick();
                ic_mem_req_valid = 1'b0;
                for (int k = 0; k < BEATS; k++) begin
                    if (pass == 0 && k == 2) begin
                        mem_resp_valid = 1'b0;
                        reset          = 1'b1;
                        #1;
                        checks++;
                        if ({ic_mem_req_ready, dc_mem_req_ready, ic_mem_resp_valid, dc_mem_resp_valid} !== 4'b0000) begin
                            errors++;
                            $display("FAIL rst_mid_during got=%b exp=0000",
                                     {ic_mem_req_ready, dc_mem_req_ready, ic_mem_resp_valid, dc_mem_resp_valid});
                        end
                        tick();
                        reset = 1'b0;
                    end
                    mem_resp_valid = 1'b1;
                    mem_resp_data  = {4{32'hD0D0_0000 + 32'(pass * 16 + k)}};
                    if (pass == 1 || k < 2) exp_ic_q.push_back(mem_resp_data);
                    #1;
                    if (pass == 0 && k >= 2) begin
                        checks++;
                        if ({ic_mem_resp_valid, dc_mem_resp_valid} !== 2'b00) begin
                            errors++;
                            $display("FAIL rst_mid_dropped%0d got=%b exp=00", k, {ic_mem_resp_valid, dc_mem_resp_valid});
                        end
                    end
                    if (pass == 0 && k == 2) begin
                        checks++;
                        if ({ic_mem_req_ready, dc_mem_req_ready} !== 2'b01) begin
                            errors++;
                            $display("FAIL rst_mid_idle got=%b exp=01", {ic_mem_req_ready, dc_mem_req_ready});
                        end
                    end
                    tick();
                end
                mem_resp_valid = 1'b0;
                #1;
                checks++;
                if (exp_ic_q.size() != 0) begin
                    errors++;
                    $display("FAIL rst_mid_pass%0d_beats got=%0d exp=0", pass, exp_ic_q.size());
                end
                tick();
            end
        end
        drive_idle();
    endtask

    task automatic test_spurious_resp();
        mem_resp_valid = 1'b1;
        mem_resp_data  = {4{32'hEEEE_5555}};
        #1;
        checks++;
        if ({ic_mem_resp_valid, dc_mem_resp_valid} !== 2'b00) begin
            errors++;
            $display("FAIL spur_routed got=%b exp=00", {ic_mem_resp_valid, dc_mem_resp_valid});
        end
        checks++;
        if ((ic_mem_req_ready ^ dc_mem_req_ready) !== 1'b1) begin
            errors++;
            $display("FAIL spur_idle got=%b exp=one_ready", {ic_mem_req_ready, dc_mem_req_ready});
        end
        tick();
        mem_resp_valid = 1'b0;
        #1;
        checks++;
        if ((ic_mem_req_ready ^ dc_mem_req_ready) !== 1'b1) begin
            errors++;
            $display("FAIL spur_no_state_change got=%b exp=one_ready", {ic_mem_req_ready, dc_mem_req_ready});
        end
        tick();
        drive_idle();
    endtask

    initial begin
        reset              = 1'b1;
        mem_req_ready      = 1'b0;
        mem_req_data_ready = 1'b0;
        drive_idle();
        @(negedge clk);
        test_reset();
        test_read_only();
        test_write_only();
        test_backpressure();
        test_contention();
        test_reset_mid_read();
        test_spurious_resp();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
